axis_adc_framer_v1_0: RTL and testbench

//  AXI-Stream master feeding the FIR slave port (s_axis_*). Samples a parallel ADC word at a programmable

---
 rtl/axis_adc_framer_v1_0_pkg.sv | 16 +
 rtl/axis_adc_framer_v1_0_if.sv | 12 +
 rtl/axis_adc_framer_v1_0_axis_sync_fifo.sv | 48 ++++
 rtl/axis_adc_framer_v1_0.sv | 78 +++++++
 tb/tb_axis_adc_framer_v1_0.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/axis_adc_framer_v1_0_pkg.sv
// Shared helpers for the ADC framer: width math and the AXIS beat layout {tlast, tdata}.
package axis_adc_framer_v1_0_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    // Beat word stored in the FIFO: tlast sits directly above the sample bits.
    function automatic int beat_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/axis_adc_framer_v1_0_if.sv
// AXI-Stream bundle carrying one sample per beat plus a frame marker.
interface axis_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_adc_framer_v1_0_axis_sync_fifo.sv
// First-word fall-through synchronous FIFO; a push into a full FIFO is taken only with a same-cycle pop.
module axis_sync_fifo
    import axis_adc_framer_v1_0_pkg::*;
#(
    parameter  int WIDTH = 17,
    parameter  int DEPTH = 8,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             aclk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    // Head is forced to zero when empty so the bus shows clean data after reset.
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/axis_adc_framer_v1_0.sv
// ADC sampler: rate divider, frame counter, offset-binary conversion and overflow tracking
// in front of a FWFT FIFO that drives the AXIS master.
module axis_adc_framer_v1_0
    import axis_adc_framer_v1_0_pkg::*;
#(
    parameter  int DATA_WIDTH      = 16,
    parameter  int FIFO_DEPTH      = 8,
    parameter  int PRESCALER_WIDTH = 16,
    parameter  int FRAME_WIDTH     = 16,
    localparam int CW              = clog2(FIFO_DEPTH) + 1,
    localparam int BW              = beat_width(DATA_WIDTH)
) (
    input  logic                       aclk,
    input  logic                       resetn,
    input  logic                       enable,
    input  logic [PRESCALER_WIDTH-1:0] prescaler,
    input  logic [FRAME_WIDTH-1:0]     frame_len,
    input  logic                       offset_binary,
    input  logic [DATA_WIDTH-1:0]      adc_data,
    axis_if.master                     m_axis,
    output logic [CW-1:0]              fifo_count,
    output logic                       overflow,
    input  logic                       clear_overflow
);
    logic [PRESCALER_WIDTH-1:0] presc_cnt;
    logic [FRAME_WIDTH-1:0]     frame_cnt;
    logic [FRAME_WIDTH-1:0]     last_idx;
    logic [DATA_WIDTH-1:0]      conv;
    logic [BW-1:0]              head;
    logic                       tick, pop, accept, drop, last, full, empty;

    assign tick     = enable && (presc_cnt >= prescaler);
    assign pop      = m_axis.tvalid && m_axis.tready;
    assign accept   = tick && (!full || pop);
    assign drop     = tick && full && !pop;
    // frame_len of 0 behaves as 1, so every sample closes a frame.
    assign last_idx = (frame_len == '0) ? '0 : frame_len - FRAME_WIDTH'(1);
    assign last     = (frame_cnt >= last_idx);
    assign conv     = {adc_data[DATA_WIDTH-1] ^ offset_binary, adc_data[DATA_WIDTH-2:0]};

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            presc_cnt <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (!enable) begin
                presc_cnt <= '0;
                frame_cnt <= '0;
            end else begin
                presc_cnt <= tick ? '0 : presc_cnt + PRESCALER_WIDTH'(1);
                // Dropped samples never occupy a frame slot.
                if (accept) frame_cnt <= last ? '0 : frame_cnt + FRAME_WIDTH'(1);
            end
            if (drop) overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    axis_sync_fifo #(
        .WIDTH (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk   (aclk),
        .resetn (resetn),
        .push   (tick),
        .pop    (pop),
        .din    ({last, conv}),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    assign m_axis.tvalid = !empty;
    assign m_axis.tlast  = head[BW-1];
    assign m_axis.tdata  = head[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_axis_adc_framer_v1_0.sv
// Directed bench for the ADC framer with a beat scoreboard checked on every accepted AXIS transfer.
module tb_axis_adc_framer_v1_0;
    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        offset_binary = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [15:0] prescaler = '0;
    logic [15:0] frame_len = '0;
    logic [15:0] adc_data = '0;
    logic [3:0]  fifo_count;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] q[$];
    logic [16:0] mon_exp;
    logic [15:0] ob_in  [3] = '{16'h8000, 16'h0000, 16'hFFFF};
    logic [15:0] ob_exp [3] = '{16'h0000, 16'h8000, 16'h7FFF};

    axis_if #(.DATA_WIDTH(16)) m_axis ();

    axis_adc_framer_v1_0 #(
        .DATA_WIDTH      (16),
        .FIFO_DEPTH      (8),
        .PRESCALER_WIDTH (16),
        .FRAME_WIDTH     (16)
    ) dut (
        .aclk           (aclk),
        .resetn         (resetn),
        .enable         (enable),
        .prescaler      (prescaler),
        .frame_len      (frame_len),
        .offset_binary  (offset_binary),
        .adc_data       (adc_data),
        .m_axis         (m_axis),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge aclk);
            n++;
        end
        #1;
        chk(tag, 32'(q.size()), 0);
        chk({tag, "_tvalid"}, 32'(m_axis.tvalid), 0);
    endtask

    // Transfers are judged half a cycle before the edge that completes them.
    always @(negedge aclk) begin
        if (resetn && m_axis.tvalid && m_axis.tready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'(q.size()), 1);
            end else begin
                mon_exp = q.pop_front();
                chk("beat", 32'({m_axis.tlast, m_axis.tdata}), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        m_axis.tready = 1'b0;
        step(3);
        chk("rst_tvalid", 32'(m_axis.tvalid), 0);
        chk("rst_tlast", 32'(m_axis.tlast), 0);
        chk("rst_tdata", 32'(m_axis.tdata), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        resetn = 1'b1;
        step(1);

        // Ramp at one sample per 4 cycles, frames of 4.
        prescaler = 16'd3; frame_len = 16'd4; m_axis.tready = 1'b1; enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            adc_data = k[15:0];
            q.push_back({(k % 4) == 3, k[15:0]});
            for (int j = 0; j < 4; j++) begin
                step(1);
                if (k == 0 && j == 2) chk("t1_lat_pre", 32'(m_axis.tvalid), 0);
                if (k == 0 && j == 3) begin
                    chk("t1_lat_valid", 32'(m_axis.tvalid), 1);
                    chk("t1_lat_data", 32'(m_axis.tdata), 0);
                end
            end
        end
        enable = 1'b0;
        drain("t1_drain");

        // Offset binary conversion; frame_len 0 marks every beat last.
        prescaler = 16'd0; frame_len = 16'd0; offset_binary = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adc_data = ob_in[i];
            q.push_back({1'b1, ob_exp[i]});
            step(1);
        end
        enable = 1'b0; offset_binary = 1'b0;
        drain("t2_drain");

        // Backpressure: 8 accepted, 4 dropped.
        frame_len = 16'd4; m_axis.tready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            adc_data = i[15:0];
            if (i < 8) q.push_back({(i % 4) == 3, i[15:0]});
            step(1);
            if (i == 7) chk("t3_ovf_before_drop", 32'(overflow), 0);
        end
        chk("t3_count_sat", 32'(fifo_count), 8);
        chk("t3_ovf", 32'(overflow), 1);

        // Drop together with clear: set wins.
        clear_overflow = 1'b1; adc_data = 16'h00AA;
        step(1);
        chk("t4_set_wins", 32'(overflow), 1);
        chk("t4_count_full", 32'(fifo_count), 8);
        enable = 1'b0;
        step(1);
        chk("t4_cleared", 32'(overflow), 0);

        // Full FIFO with tick and pop in the same cycle.
        clear_overflow = 1'b0; enable = 1'b1; m_axis.tready = 1'b1; adc_data = 16'd100;
        q.push_back({1'b0, 16'd100});
        step(1);
        chk("t4_pushpop_count", 32'(fifo_count), 8);
        chk("t4_pushpop_ovf", 32'(overflow), 0);
        enable = 1'b0;
        drain("t4_drain");

        // Shrink frame_len mid-frame at frame_cnt=5.
        frame_len = 16'd8; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) frame_len = 16'd2;
            adc_data = 16'(i + 200);
            q.push_back({(i == 5 || i == 7), 16'(i + 200)});
            step(1);
        end
        enable = 1'b0;
        drain("t5_drain");

        // Disable with 3 buffered, then fresh restart, then reset mid-burst.
        frame_len = 16'd4; prescaler = 16'd0; m_axis.tready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adc_data = 16'(i + 300);
            q.push_back({1'b0, 16'(i + 300)});
            step(1);
        end
        enable = 1'b0;
        step(4);
        chk("t6_hold_count", 32'(fifo_count), 3);
        m_axis.tready = 1'b1;
        drain("t6_drain");
        chk("t6_drain_count", 32'(fifo_count), 0);

        prescaler = 16'd2; m_axis.tready = 1'b0; adc_data = 16'd50; enable = 1'b1;
        q.push_back({1'b0, 16'd50});
        step(2);
        chk("t6_no_early_tick", 32'(m_axis.tvalid), 0);
        step(1);
        chk("t6_first_tick", 32'(m_axis.tvalid), 1);
        chk("t6_first_data", 32'(m_axis.tdata), 50);
        chk("t6_fresh_frame", 32'(m_axis.tlast), 0);
        adc_data = 16'd60;
        q.push_back({1'b0, 16'd60});
        step(3);
        chk("t6_burst_count", 32'(fifo_count), 2);

        resetn = 1'b0;
        step(1);
        chk("t6_rst_tvalid", 32'(m_axis.tvalid), 0);
        chk("t6_rst_count", 32'(fifo_count), 0);
        chk("t6_rst_tdata", 32'(m_axis.tdata), 0);
        chk("t6_rst_tlast", 32'(m_axis.tlast), 0);
        q.delete();
        resetn = 1'b1; enable = 1'b0;
        step(2);
        chk("t6_post_rst_tvalid", 32'(m_axis.tvalid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
